// File: rtl/spi_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : spi_ctrl_pkg
// Purpose  : Opcodes, FSM state type and default widths for spi_ram_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_ctrl_pkg;

  localparam int c_def_addr_width = 8;
  localparam int c_def_data_width = 8;

  localparam logic [1:0] c_op_wr_addr = 2'b00;
  localparam logic [1:0] c_op_wr_data = 2'b01;
  localparam logic [1:0] c_op_rd_addr = 2'b10;
  localparam logic [1:0] c_op_rd_data = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_DATA = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_ram_mem.sv
//------------------------------------------------------------------------------
// Module   : spi_ram_mem
// Purpose  : Single-port RAM, synchronous write, registered read, no reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_ram_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    if (re) begin
      r_dout <= r_mem[addr];
    end
  end

  assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module   : spi_ram_ctrl
// Purpose  : Decodes SPI frames into RAM address/write/read operations.
//            Optional macro SPI_CTRL_AUTOINC_EN: post-increment addresses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_ram_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = c_def_addr_width,
  parameter int DATA_WIDTH = c_def_data_width
) (
  input  logic                  i_spi_ctrl_clk,
  input  logic                  i_spi_ctrl_rst_n,
  input  logic [DATA_WIDTH+1:0] i_spi_ctrl_rx_data,
  input  logic                  i_spi_ctrl_rx_valid,
  output logic [DATA_WIDTH-1:0] o_spi_ctrl_tx_data,
  output logic                  o_spi_ctrl_tx_valid,
  output logic                  o_spi_ctrl_busy,
  output logic                  o_spi_ctrl_drop
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;
  logic                  r_drop;

  logic [1:0]            w_opcode;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [ADDR_WIDTH-1:0] w_payload_addr;
  logic                  w_accept;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_dout;

  assign w_opcode       = i_spi_ctrl_rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign w_payload      = i_spi_ctrl_rx_data[DATA_WIDTH-1:0];
  assign w_payload_addr = ADDR_WIDTH'(w_payload);
  assign w_accept       = i_spi_ctrl_rx_valid && (r_state == ST_IDLE);

  // The port is shared: WRITE owns the address bus, otherwise the read pointer does.
  assign w_ram_we   = (r_state == ST_WRITE);
  assign w_ram_re   = (r_state == ST_RD_REQ);
  assign w_ram_addr = w_ram_we ? r_wr_addr : r_rd_addr;

  spi_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk  (i_spi_ctrl_clk),
    .we   (w_ram_we),
    .re   (w_ram_re),
    .addr (w_ram_addr),
    .din  (r_wr_data),
    .dout (w_ram_dout)
  );

  always_ff @(posedge i_spi_ctrl_clk or negedge i_spi_ctrl_rst_n) begin
    if (!i_spi_ctrl_rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_drop     <= i_spi_ctrl_rx_valid && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (i_spi_ctrl_rx_valid) begin
            case (w_opcode)
              c_op_wr_addr: r_wr_addr <= w_payload_addr;
              c_op_rd_addr: r_rd_addr <= w_payload_addr;
              c_op_wr_data: r_state   <= ST_WRITE;
              c_op_rd_data: r_state   <= ST_RD_REQ;
              default:      r_state   <= ST_IDLE;
            endcase
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
`ifdef SPI_CTRL_AUTOINC_EN
          r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
`endif
        end
        ST_RD_REQ: begin
          r_state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          r_tx_data  <= w_ram_dout;
          r_tx_valid <= 1'b1;
          r_state    <= ST_IDLE;
`ifdef SPI_CTRL_AUTOINC_EN
          r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write payload is deliberately outside the reset domain; it only matters once WRITE is entered.
  always_ff @(posedge i_spi_ctrl_clk) begin
    if (w_accept && (w_opcode == c_op_wr_data)) begin
      r_wr_data <= w_payload;
    end
  end

  assign o_spi_ctrl_tx_data  = r_tx_data;
  assign o_spi_ctrl_tx_valid = r_tx_valid;
  assign o_spi_ctrl_busy     = (r_state != ST_IDLE);
  assign o_spi_ctrl_drop     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_ram_ctrl
// Purpose  : Self-checking bench for spi_ram_ctrl against a frame-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_ram_ctrl;

`ifdef SPI_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       drop;

  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_wr_addr;
  logic [7:0] m_rd_addr;
  logic [7:0] m_tx_data;

  int n_cmp = 0;
  int n_err = 0;

  spi_ram_ctrl #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8)
  ) dut (
    .i_spi_ctrl_clk      (clk),
    .i_spi_ctrl_rst_n    (rst_n),
    .i_spi_ctrl_rx_data  (rx_data),
    .i_spi_ctrl_rx_valid (rx_valid),
    .o_spi_ctrl_tx_data  (tx_data),
    .o_spi_ctrl_tx_valid (tx_valid),
    .o_spi_ctrl_busy     (busy),
    .o_spi_ctrl_drop     (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr_addr = 8'h00;
    m_rd_addr = 8'h00;
    m_tx_data = 8'h00;
  endtask

  task automatic do_wr_addr(input logic [7:0] a);
    rx_data  = {2'b00, a};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    n_cmp++;
    if (drop !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wr_addr_idle: drop=%b busy=%b required 0 0", drop, busy);
    end
    m_wr_addr = a;
  endtask

  task automatic do_rd_addr(input logic [7:0] a);
    rx_data  = {2'b10, a};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    n_cmp++;
    if (drop !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rd_addr_idle: drop=%b busy=%b required 0 0", drop, busy);
    end
    m_rd_addr = a;
  endtask

  task automatic do_wr_data(input logic [7:0] d);
    rx_data  = {2'b01, d};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || drop !== 1'b0) begin
      n_err++;
      $display("FAIL wr_data_busy: busy=%b drop=%b required 1 0", busy, drop);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || drop !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wr_data_done: busy=%b drop=%b tx_valid=%b required 0 0 0", busy, drop, tx_valid);
    end
    m_mem[m_wr_addr]   = d;
    m_known[m_wr_addr] = 1'b1;
    if (AUTOINC) m_wr_addr = m_wr_addr + 8'd1;
  endtask

  // Ends on the cycle tx_valid is high so a follow-on frame can be issued there.
  task automatic do_read();
    logic [7:0] junk;
    logic [7:0] exp;
    junk     = 8'($urandom);
    exp      = m_mem[m_rd_addr];
    rx_data  = {2'b11, junk};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || tx_valid !== 1'b0 || drop !== 1'b0) begin
      n_err++;
      $display("FAIL rd_cycle1: busy=%b tx_valid=%b drop=%b required 1 0 0", busy, tx_valid, drop);
    end
    step();
    n_cmp++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_cycle2: busy=%b tx_valid=%b required 1 0", busy, tx_valid);
    end
    step();
    n_cmp++;
    if (tx_valid !== 1'b1 || busy !== 1'b0 || tx_data !== exp) begin
      n_err++;
      $display("FAIL rd_result: tx_valid=%b busy=%b tx_data=%h required 1 0 %h (addr %h)",
               tx_valid, busy, tx_data, exp, m_rd_addr);
    end
    m_tx_data = exp;
    if (AUTOINC) m_rd_addr = m_rd_addr + 8'd1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || drop !== 1'b0 || tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_in: busy=%b tx_valid=%b drop=%b tx_data=%h required 0 0 0 00",
               busy, tx_valid, drop, tx_data);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || drop !== 1'b0 || tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_out: busy=%b tx_valid=%b drop=%b tx_data=%h required 0 0 0 00",
               busy, tx_valid, drop, tx_data);
    end
    model_reset();
  endtask

  task automatic test_default_addr();
    logic [7:0] d;
    d = 8'($urandom);
    do_wr_data(d);
    do_read();
    n_cmp++;
    if (tx_data !== d) begin
      n_err++;
      $display("FAIL default_addr: tx_data=%h required %h", tx_data, d);
    end
    step();
  endtask

  task automatic test_init_ram();
    for (int i = 0; i < 256; i++) begin
      do_wr_addr(8'(i));
      do_wr_data(8'($urandom));
    end
  endtask

  task automatic test_basic();
    do_wr_addr(8'hA5);
    do_wr_data(8'h3C);
    do_rd_addr(8'hA5);
    do_read();
    n_cmp++;
    if (tx_data !== 8'h3C) begin
      n_err++;
      $display("FAIL basic_rw: tx_data=%h required 3c", tx_data);
    end
    step();
    n_cmp++;
    if (tx_valid !== 1'b0 || tx_data !== m_tx_data) begin
      n_err++;
      $display("FAIL tx_hold: tx_valid=%b tx_data=%h required 0 %h", tx_valid, tx_data, m_tx_data);
    end
  endtask

  task automatic test_drop();
    int         drops, drop_at, txs, tx_at;
    logic [7:0] tx_val, exp;
    do_rd_addr(8'($urandom));
    exp      = m_mem[m_rd_addr];
    drops    = 0; drop_at = -1; txs = 0; tx_at = -1; tx_val = '0;
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (drop === 1'b1) begin drops++; drop_at = c; end
      if (tx_valid === 1'b1) begin txs++; tx_at = c; tx_val = tx_data; end
      if (c == 1) begin
        rx_data  = {2'b11, 8'h55};
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
    end
    n_cmp++;
    if (drops != 1 || drop_at != 2) begin
      n_err++;
      $display("FAIL drop_pulse: count=%0d at=%0d required 1 at 2", drops, drop_at);
    end
    n_cmp++;
    if (txs != 1 || tx_at != 3 || tx_val !== exp) begin
      n_err++;
      $display("FAIL drop_single_tx: count=%0d at=%0d data=%h required 1 at 3 data %h",
               txs, tx_at, tx_val, exp);
    end
    m_tx_data = exp;
    if (AUTOINC) m_rd_addr = m_rd_addr + 8'd1;
  endtask

  task automatic test_accept_on_tx();
    logic [7:0] b, d;
    b = 8'($urandom);
    d = 8'($urandom);
    do_rd_addr(8'($urandom));
    do_read();
    do_read();
    do_wr_addr(b);
    do_wr_data(d);
    do_rd_addr(b);
    do_read();
    n_cmp++;
    if (tx_data !== d) begin
      n_err++;
      $display("FAIL accept_on_tx: tx_data=%h required %h", tx_data, d);
    end
    step();
  endtask

  task automatic test_reset_in_read();
    int txs;
    for (int stage = 1; stage <= 2; stage++) begin
      do_rd_addr(8'($urandom));
      rx_data  = {2'b11, 8'h00};
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      if (stage == 2) step();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset_async_s%0d: busy=%b tx_valid=%b tx_data=%h required 0 0 00",
                 stage, busy, tx_valid, tx_data);
      end
      step();
      step();
      rst_n = 1'b1;
      txs   = 0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (tx_valid !== 1'b0) txs++;
      end
      n_cmp++;
      if (txs != 0 || busy !== 1'b0 || tx_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset_abort_s%0d: tx_pulses=%0d busy=%b tx_data=%h required 0 0 00",
                 stage, txs, busy, tx_data);
      end
      model_reset();
      do_read();
      step();
    end
  endtask

  task automatic test_reset_in_write();
    logic [7:0] a, old_v, new_v;
    a     = 8'($urandom);
    new_v = 8'($urandom);
    do_wr_addr(a);
    old_v    = m_mem[a];
    rx_data  = {2'b01, new_v};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    model_reset();
    do_rd_addr(a);
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    step();
    n_cmp++;
    if (tx_valid !== 1'b1 || (tx_data !== old_v && tx_data !== new_v)) begin
      n_err++;
      $display("FAIL reset_write: tx_valid=%b tx_data=%h required 1 and %h or %h",
               tx_valid, tx_data, old_v, new_v);
    end
    m_mem[a]  = tx_data;
    m_tx_data = tx_data;
    if (AUTOINC) m_rd_addr = m_rd_addr + 8'd1;
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] old0, exp_ff, exp_00;
    old0   = m_mem[8'h00];
    exp_ff = AUTOINC ? 8'h11 : 8'h22;
    exp_00 = AUTOINC ? 8'h22 : old0;
    do_wr_addr(8'hFF);
    do_wr_data(8'h11);
    do_wr_data(8'h22);
    do_rd_addr(8'hFF);
    do_read();
    n_cmp++;
    if (tx_data !== exp_ff) begin
      n_err++;
      $display("FAIL wrap_ff: tx_data=%h required %h", tx_data, exp_ff);
    end
    do_rd_addr(8'h00);
    do_read();
    n_cmp++;
    if (tx_data !== exp_00) begin
      n_err++;
      $display("FAIL wrap_00: tx_data=%h required %h", tx_data, exp_00);
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_wr_addr(8'h01);
    do_wr_data(8'hFF);
    do_rd_addr(8'h01);
    do_read();
    n_cmp++;
    if (tx_data !== 8'hFF) begin
      n_err++;
      $display("FAIL back_to_back: tx_data=%h required ff", tx_data);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: do_wr_addr(8'($urandom));
        1: do_wr_data(8'($urandom));
        2: do_rd_addr(8'($urandom));
        3: do_read();
        default: begin
          step();
          n_cmp++;
          if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== m_tx_data) begin
            n_err++;
            $display("FAIL idle_hold: tx_valid=%b busy=%b tx_data=%h required 0 0 %h",
                     tx_valid, busy, tx_data, m_tx_data);
          end
        end
      endcase
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = 'x;
      m_known[i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_default_addr();
    test_init_ram();
    test_basic();
    test_drop();
    test_accept_on_tx();
    test_reset_in_read();
    test_reset_in_write();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
